vram_pixel_writer: RTL and testbench
====================================

VRAM_PIXEL_WRITER -- requirements
Module: vram_pixel_writer

Interface
REQ-001 SHALL have parameter XW, default 8, x coordinate width in pixels.
REQ-002 SHALL have parameter YW, default 8, y coordinate width in lines.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pix_valid  input  1  pixel write request.
REQ-006 SHALL have port pix_ready  output  1  request accepted when pix_valid && pix_ready.
REQ-007 SHALL have port pix_x  input  XW  pixel column.
REQ-008 SHALL have port pix_y  input  YW  pixel line.
REQ-009 SHALL have port pix_color  input  4  palette index.
REQ-010 SHALL have port pix_pair  input  1  write pix_color to both nibbles of the byte, without a read.
REQ-011 SHALL have port clr_start  input  1  one-cycle pulse starting a screen clear.
REQ-012 SHALL have port clr_color  input  4  clear palette index.
REQ-013 SHALL have port clr_busy  output  1  clear in progress.
REQ-014 SHALL have port vram_addr  output  XW+YW-1  byte address {y, x[XW-1:1]}.
REQ-015 SHALL have port vram_din  output  8  write data to VRAM.
REQ-016 SHALL have port vram_we  output  1  VRAM write strobe.
REQ-017 SHALL have port vram_dout  input  8  VRAM synchronous read data, valid one cycle after vram_addr.

Function
REQ-018 SHALL use packing with even x in vram_din[3:0] and odd x in vram_din[7:4], matching the video scan-out.
REQ-019 SHALL implement states IDLE, ADDR, READ, WRITE and CLR; vram_addr, vram_din and vram_we SHALL be registered.
REQ-020 SHALL drive pix_ready combinationally high only in IDLE, and low in a cycle where clr_start is asserted.
REQ-021 SHALL, on acceptance in cycle N with pix_pair=0, latch x, y and colour, set vram_addr to {y, x[XW-1:1]}, and go to ADDR.
REQ-022 SHALL go from ADDR to READ, and in READ merge vram_dout with the new nibble in the selected half, keeping the other half unchanged.
REQ-023 SHALL assert vram_we for exactly one cycle (WRITE, cycle N+3) and return to IDLE, so that pix_ready is high again in N+4.
REQ-024 SHALL, on acceptance with pix_pair=1, go directly to WRITE with vram_din={c,c}, with vram_we in N+1 and pix_ready high again in N+2.
REQ-025 SHALL accept every coordinate value; no range clipping.
REQ-026 SHALL hold vram_we low in every state except WRITE and CLR.
REQ-027 SHALL, in CLR, write {clr_color,clr_color} to every address from 0 up to 2^(XW+YW-1)-1, one address per cycle with vram_we high, then go to IDLE.
REQ-028 SHALL hold clr_busy high in exactly the CLR cycles; clr_color SHALL be latched at start.
REQ-029 SHALL ignore clr_start when not in IDLE; when clr_start and pix_valid are both asserted in IDLE, the clear SHALL win and the pixel SHALL stay pending.

Reset
REQ-030 SHALL, when reset is asserted, go to IDLE with vram_we=0, vram_addr=0, vram_din=0 and clr_busy=0 on the next edge.
REQ-031 SHALL, on reset mid-operation (ADDR, READ, WRITE or CLR), abort with no further write; any pending pixel SHALL be dropped.

Configuration
REQ-032 SHALL include the clear engine (CLR state, clr_start, clr_color) only when VRAM_CLEAR_EN is defined.
REQ-033 SHALL, without VRAM_CLEAR_EN, keep the ports, ignore clr_start and clr_color, tie clr_busy to 0, and set pix_ready = (state==IDLE).

Verification
REQ-034 SHALL cover: VRAM byte 0x5A at {y=3,x=7>>1}; write x=7,y=3,c=0x9,pair=0 -> one vram_we in N+3, addr 0x0183, din 0x9A, pix_ready high in N+4.
REQ-035 SHALL cover: x=6,y=3,c=0x2 on byte 0x5A -> din 0x52, other nibble preserved.
REQ-036 SHALL cover: pair=1,x=255,y=255,c=0xF -> vram_we in N+1 only, addr 0x7FFF, din 0xFF, no read cycle.
REQ-037 SHALL cover, with VRAM_CLEAR_EN: clr_start with clr_color=0x1 -> 32768 consecutive writes of 0x11 at addresses 0..0x7FFF, clr_busy high exactly 32768 cycles, pix_ready low throughout.
REQ-038 SHALL cover: clr_start and pix_valid in the same IDLE cycle -> clear runs first, then the pixel is accepted; without the macro, the pixel is accepted immediately and clr_busy stays 0.
REQ-039 SHALL cover: reset asserted in the READ cycle -> no vram_we pulse, and the next edge gives IDLE with all outputs 0.

Source files
------------

// File: rtl/vram_pixel_writer_if.sv
// rtl/vram_pixel_writer_if.sv - pixel request, clear control and VRAM port bundle for vram_pixel_writer
interface vram_pixel_writer_if #(
    parameter int XW = 8,
    parameter int YW = 8
);
    logic              pix_valid;
    logic              pix_ready;
    logic [XW-1:0]     pix_x;
    logic [YW-1:0]     pix_y;
    logic [3:0]        pix_color;
    logic              pix_pair;
    logic              clr_start;
    logic [3:0]        clr_color;
    logic              clr_busy;
    logic [XW+YW-2:0]  vram_addr;
    logic [7:0]        vram_din;
    logic              vram_we;
    logic [7:0]        vram_dout;

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, pix_pair,
        input  clr_start, clr_color, vram_dout,
        output pix_ready, clr_busy, vram_addr, vram_din, vram_we
    );

    modport master (
        output pix_valid, pix_x, pix_y, pix_color, pix_pair,
        output clr_start, clr_color, vram_dout,
        input  pix_ready, clr_busy, vram_addr, vram_din, vram_we
    );
endinterface

// File: rtl/vram_pixel_writer.sv
// rtl/vram_pixel_writer.sv - 4bpp read-modify-write pixel writer with optional screen clear (VRAM_CLEAR_EN)
module vram_pixel_writer #(
    parameter int XW = 8,
    parameter int YW = 8
) (
    input  logic               clk,
    input  logic               reset,
    vram_pixel_writer_if.slave bus
);
    localparam int AW = XW + YW - 1;

`ifdef VRAM_CLEAR_EN
    typedef enum logic [2:0] {IDLE, ADDR, READ, WRITE, CLR} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR, READ, WRITE} state_t;
`endif

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic            we_q, we_d;
    logic            sel_hi_q, sel_hi_d;
    logic [3:0]      color_q, color_d;
    logic            clr_go;
    logic            accept;

`ifdef VRAM_CLEAR_EN
    // A clear request only takes effect from IDLE and pre-empts a pending pixel.
    assign clr_go        = (state_q == IDLE) && bus.clr_start;
    assign bus.pix_ready = (state_q == IDLE) && !bus.clr_start;
    assign bus.clr_busy  = (state_q == CLR);
`else
    logic unused_clr;
    assign unused_clr    = ^{bus.clr_start, bus.clr_color};
    assign clr_go        = 1'b0;
    assign bus.pix_ready = (state_q == IDLE);
    assign bus.clr_busy  = 1'b0;
`endif

    assign accept        = bus.pix_valid && bus.pix_ready;
    assign bus.vram_addr = addr_q;
    assign bus.vram_din  = din_q;
    assign bus.vram_we   = we_q;

    // Next-state and next-output logic; the write strobe defaults low each cycle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        din_d    = din_q;
        we_d     = 1'b0;
        sel_hi_d = sel_hi_q;
        color_d  = color_q;
        case (state_q)
            IDLE: begin
                if (clr_go) begin
`ifdef VRAM_CLEAR_EN
                    state_d = CLR;
                    addr_d  = '0;
                    din_d   = {bus.clr_color, bus.clr_color};
                    we_d    = 1'b1;
`endif
                end else if (accept) begin
                    addr_d   = {bus.pix_y, bus.pix_x[XW-1:1]};
                    sel_hi_d = bus.pix_x[0];
                    color_d  = bus.pix_color;
                    if (bus.pix_pair) begin
                        // Both nibbles get the colour, so the old byte is irrelevant.
                        din_d   = {bus.pix_color, bus.pix_color};
                        we_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                // Address is on the bus this cycle; read data arrives next cycle.
                state_d = READ;
            end
            READ: begin
                // Odd x lives in the high nibble, even x in the low nibble.
                if (sel_hi_q) begin
                    din_d = {color_q, bus.vram_dout[3:0]};
                end else begin
                    din_d = {bus.vram_dout[7:4], color_q};
                end
                we_d    = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
            end
`ifdef VRAM_CLEAR_EN
            CLR: begin
                if (addr_q == {AW{1'b1}}) begin
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
                    we_d   = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered VRAM outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
            sel_hi_q <= 1'b0;
            color_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            we_q     <= we_d;
            sel_hi_q <= sel_hi_d;
            color_q  <= color_d;
        end
    end
endmodule

// File: tb/tb_vram_pixel_writer.sv
// tb/tb_vram_pixel_writer.sv - directed self-checking bench for vram_pixel_writer (VRAM_CLEAR_EN aware)
module tb_vram_pixel_writer;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   we_total = 0;
    int   clr_writes = 0;
    int   clr_bad = 0;
    int   clr_next = 0;
    int   busy_cyc = 0;
    int   rdy_bad = 0;
    int   we_snap;
    logic [7:0] mem [0:32767];

    always #5 clk = ~clk;

    vram_pixel_writer_if #(.XW(8), .YW(8)) bus ();

    vram_pixel_writer #(.XW(8), .YW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous VRAM model: read data valid one cycle after the address.
    always @(posedge clk) begin
        if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_din;
        bus.vram_dout <= mem[bus.vram_addr];
    end

    // Write monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.vram_we === 1'b1) begin
            we_total++;
            if (bus.clr_busy === 1'b1) begin
                if (bus.vram_addr !== clr_next[14:0] || bus.vram_din !== 8'h11) clr_bad++;
                clr_next++;
                clr_writes++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pix(input logic v, input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] c, input logic pair);
        bus.pix_valid = v;
        bus.pix_x     = x;
        bus.pix_y     = y;
        bus.pix_color = c;
        bus.pix_pair  = pair;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        reset         = 1'b1;
        bus.clr_start = 1'b0;
        bus.clr_color = 4'h0;
        drive_pix(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        step();
        step();
        chk("rst_we",    {31'd0, bus.vram_we},   32'd0);
        chk("rst_addr",  {17'd0, bus.vram_addr}, 32'd0);
        chk("rst_din",   {24'd0, bus.vram_din},  32'd0);
        chk("rst_busy",  {31'd0, bus.clr_busy},  32'd0);
        reset = 1'b0;
        step();
        chk("idle_ready", {31'd0, bus.pix_ready}, 32'd1);

        // Odd pixel RMW: x=7,y=3,c=9 over 0x5A -> 0x9A at 0x0183.
        mem[15'h0183] = 8'h5A;
        drive_pix(1'b1, 8'd7, 8'd3, 4'h9, 1'b0);
        step();                                       // N+1 ADDR
        drive_pix(1'b0, 8'd0, 8'd0, 4'h0, 1'b0);
        chk("odd_n1_we",    {31'd0, bus.vram_we},   32'd0);
        chk("odd_n1_addr",  {17'd0, bus.vram_addr}, 32'h0183);
        chk("odd_n1_ready", {31'd0, bus.pix_ready}, 32'd0);
        step();                                       // N+2 READ
        chk("odd_n2_we",    {31'd0, bus.vram_we},   32'd0);
        chk("odd_n2_ready", {31'd0, bus.pix_ready}, 32'd0);
        step();                                       // N+3 WRITE
        chk("odd_n3_we",    {31'd0, bus.vram_we},   32'd1);
        chk("odd_n3_addr",  {17'd0, bus.vram_addr}, 32'h0183);
        chk("odd_n3_din",   {24'd0, bus.vram_din},  32'h9A);
        step();                                       // N+4 IDLE
        chk("odd_n4_we",    {31'd0, bus.vram_we},   32'd0);
        chk("odd_n4_ready", {31'd0, bus.pix_ready}, 32'd1);
        chk("odd_mem",      {24'd0, mem[15'h0183]}, 32'h9A);

        // Even pixel RMW: x=6,y=3,c=2 over 0x5A -> 0x52.
        mem[15'h0183] = 8'h5A;
        drive_pix(1'b1, 8'd6, 8'd3, 4'h2, 1'b0);
        step();
        drive_pix(1'b0, 8'd0, 8'd0, 4'h0, 1'b0);
        step();
        step();
        chk("even_we",   {31'd0, bus.vram_we},   32'd1);
        chk("even_addr", {17'd0, bus.vram_addr}, 32'h0183);
        chk("even_din",  {24'd0, bus.vram_din},  32'h52);
        step();
        chk("even_ready", {31'd0, bus.pix_ready}, 32'd1);

        // Pair write at the far corner: no read cycle.
        drive_pix(1'b1, 8'd255, 8'd255, 4'hF, 1'b1);
        step();                                       // N+1 WRITE
        drive_pix(1'b0, 8'd0, 8'd0, 4'h0, 1'b0);
        chk("pair_n1_we",   {31'd0, bus.vram_we},   32'd1);
        chk("pair_n1_addr", {17'd0, bus.vram_addr}, 32'h7FFF);
        chk("pair_n1_din",  {24'd0, bus.vram_din},  32'hFF);
        step();                                       // N+2 IDLE
        chk("pair_n2_we",    {31'd0, bus.vram_we},   32'd0);
        chk("pair_n2_ready", {31'd0, bus.pix_ready}, 32'd1);

        // Clear and pixel requested together.
        bus.clr_start = 1'b1;
        bus.clr_color = 4'h1;
        drive_pix(1'b1, 8'd0, 8'd0, 4'h5, 1'b1);
`ifdef VRAM_CLEAR_EN
        chk("clr_ready_low", {31'd0, bus.pix_ready}, 32'd0);
        step();
        bus.clr_start = 1'b0;
        bus.clr_color = 4'h0;
        for (int i = 0; i < 40000 && bus.clr_busy === 1'b1; i++) begin
            if (bus.pix_ready !== 1'b0) rdy_bad++;
            busy_cyc++;
            step();
        end
        chk("clr_busy_cycles", busy_cyc,   32'd32768);
        chk("clr_writes",      clr_writes, 32'd32768);
        chk("clr_bad_writes",  clr_bad,    32'd0);
        chk("clr_ready_bad",   rdy_bad,    32'd0);
        chk("clr_mem_last",    {24'd0, mem[15'h7FFF]}, 32'h11);
        chk("post_clr_ready",  {31'd0, bus.pix_ready}, 32'd1);
        step();
        drive_pix(1'b0, 8'd0, 8'd0, 4'h0, 1'b0);
        chk("pend_we",   {31'd0, bus.vram_we},   32'd1);
        chk("pend_addr", {17'd0, bus.vram_addr}, 32'h0000);
        chk("pend_din",  {24'd0, bus.vram_din},  32'h55);
`else
        chk("noclr_ready", {31'd0, bus.pix_ready}, 32'd1);
        step();
        bus.clr_start = 1'b0;
        drive_pix(1'b0, 8'd0, 8'd0, 4'h0, 1'b0);
        chk("noclr_busy", {31'd0, bus.clr_busy}, 32'd0);
        chk("noclr_we",   {31'd0, bus.vram_we},  32'd1);
        chk("noclr_din",  {24'd0, bus.vram_din}, 32'h55);
`endif
        step();

        // Reset during READ: no write, outputs cleared on the next edge.
        mem[15'h0183] = 8'h5A;
        drive_pix(1'b1, 8'd7, 8'd3, 4'h9, 1'b0);
        step();                                       // ADDR
        drive_pix(1'b0, 8'd0, 8'd0, 4'h0, 1'b0);
        step();                                       // READ
        we_snap = we_total;
        reset = 1'b1;
        step();
        chk("rr_we",    {31'd0, bus.vram_we},   32'd0);
        chk("rr_addr",  {17'd0, bus.vram_addr}, 32'd0);
        chk("rr_din",   {24'd0, bus.vram_din},  32'd0);
        chk("rr_busy",  {31'd0, bus.clr_busy},  32'd0);
        reset = 1'b0;
        step();
        step();
        step();
        chk("rr_no_pulse", we_total, we_snap);
        chk("rr_mem",      {24'd0, mem[15'h0183]}, 32'h5A);
        chk("rr_ready",    {31'd0, bus.pix_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
